spi_slave_core: RTL
===================

// Module: spi_slave_core
// PURPOSE
//  Synthesizable, parametrised SPI slave. Successor to the fixed-0xA5, mode-0-only behavioural bench slave.
//  Oversamples the external SPI pins in the system clock domain and supports all four CPOL/CPHA modes.
//  Supports any word width, back-to-back words within one CS frame, and a valid/ready TX buffer.
//  Sits between the SPI pads and a register or bus adapter.
//  Also serves as the bench SPI target for the SPI master.
// PARAMETERS
//  DATA_W       8      bits per SPI word (>=2)
//  CPOL         0      SCK idle level
//  CPHA         0      0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing
//  SYNC_STAGES  2      synchroniser flops on sck, cs_n and mosi (>=2)
//  DEFAULT_TX   'hA5   word sent when no TX word is buffered (truncated/zero-extended to DATA_W)
// PORTS
//  clk          in   1       system clock; f_clk >= 8 x f_sck
//  rst_n        in   1       asynchronous active-low reset
//  sck          in   1       SPI clock (async)
//  cs_n         in   1       SPI chip select, active low (async)
//  mosi         in   1       master-out data (async)
//  miso         out  1       slave-out data
//  miso_oe      out  1       output enable for miso pad driver
//  tx_data      in   DATA_W  next word to transmit
//  tx_valid     in   1       tx_data valid
//  tx_ready     out  1       1-entry TX buffer empty; handshake completes when tx_valid & tx_ready
//  rx_data      out  DATA_W  last complete received word, MSB first on wire
//  rx_valid     out  1       1-clk pulse when rx_data updates
//  busy         out  1       synchronised cs_n low (frame active)
//  tx_underrun  out  1       1-clk pulse: word started with TX buffer empty
// BEHAVIOUR
//  Reset: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, tx_underrun=0.
//    Reset also empties the TX buffer, clears the synchronisers and puts the FSM in IDLE.
//  Sync: sck, cs_n and mosi each pass through SYNC_STAGES flops.
//    Edges are detected on synced sck only.
//    leading edge = CPOL -> !CPOL; trailing edge = !CPOL -> CPOL.
//    sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
//  FSM IDLE -> LOAD on synced cs_n fall.
//    LOAD (1 clk): shift_tx <= buffer if full, else DEFAULT_TX with tx_underrun pulse; buffer emptied.
//      bit_cnt <= DATA_W-1.
//      If CPHA=0, miso <= shift_tx MSB. If CPHA=1, the MSB is driven on the first shift edge.
//    LOAD -> SHIFT.
//  SHIFT, sample edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}.
//    On the last bit (bit_cnt==0): rx_data <= assembled word; rx_valid pulses on the next clk.
//    FSM -> LOAD for the next word if cs_n is still low.
//  SHIFT, shift edge: miso <= next bit, MSB first.
//    CPHA=0: the shift edge after the final sample is ignored; LOAD drives the next MSB.
//  Latency: miso changes 1 clk after the detected shift edge (SYNC_STAGES+1 clk after the pad edge).
//    rx_valid rises SYNC_STAGES+1 clk after the final sample pad edge.
//  busy = !cs_n_sync. miso_oe = busy. miso = 0 whenever miso_oe=0.
//  TX buffer: loaded on tx_valid & tx_ready; tx_ready=0 while full.
//    A load in the same clk as LOAD consumption does not count for the current word; it fills the buffer for the next word.
//    Buffer content persists across frames until consumed.
//  cs_n rise mid-word (synced): abort to IDLE.
//    Partial rx discarded: no rx_valid, rx_data unchanged.
//    The consumed TX word is lost.
//    miso_oe drops on the same clk busy falls.
//  cs_n rise exactly after the final sample edge: the word completes and rx_valid pulses; no new LOAD.
//  sck edges while cs_n high are ignored.
//  async rst_n mid-frame: immediate reset values; operation resumes at the next cs_n fall.
// TESTING
//  1 Mode 0, DATA_W=8, buffer empty; master sends 0x3C -> master reads 0xA5; rx_data=0x3C with one rx_valid pulse; one tx_underrun pulse.
//  2 tx_data=0x5A handshaken before CS; master sends 0x00 -> master reads 0x5A.
//    tx_ready=0 until LOAD, then 1; tx_underrun stays 0.
//  3 CPOL=1, CPHA=1, DATA_W=16; tx 0x1234; master sends 0xBEEF -> master reads 0x1234; rx_data=0xBEEF.
//  4 One CS frame with two words; 0x11 preloaded; 0x22 loaded during word 1; master sends 0xC3 then 0x3C.
//    -> master reads 0x11 then 0x22; rx_valid pulses twice with 0xC3 then 0x3C.
//  5 cs_n raised after 3 sample edges -> no rx_valid; busy=0; miso_oe=0.
//    The next frame (master sends 0x81) returns rx_data=0x81 with a correct MSB.
//  6 rst_n pulsed mid-word with buffer full -> all outputs at reset values, tx_ready=1.
//    Next frame returns DEFAULT_TX.

Source files
------------

// File: rtl/spi_slave_core_if.sv
// Parallel-side bundle of the SPI slave core:
// TX valid/ready buffer input plus RX word/status outputs.
interface spi_slave_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              tx_underrun;

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output busy,
        output tx_underrun
    );

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy,
        input  tx_underrun
    );
endinterface

// File: rtl/spi_slave_core.sv
// Oversampling SPI slave, all CPOL/CPHA modes, any word width,
// back-to-back words per frame and a 1-entry valid/ready TX buffer.
module spi_slave_core #(
    parameter int                DATA_W      = 8,
    parameter int                CPOL        = 0,
    parameter int                CPHA        = 0,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = DATA_W'('hA5)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    spi_slave_core_if.slave bus
);

    localparam int             CW       = $clog2(DATA_W);
    localparam logic           IDLE_LVL = (CPOL != 0);
    localparam logic           PHA      = (CPHA != 0);
    localparam logic [CW-1:0]  LAST     = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [SYNC_STAGES-1:0] sck_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sck_q;
    logic                   cs_q;

    logic                   buf_full;
    logic [DATA_W-1:0]      buf_data;
    logic [DATA_W-1:0]      tx_shift;
    logic [DATA_W-2:0]      rx_shift;
    logic [CW-1:0]          bit_cnt;
    logic                   miso_q;
    logic [DATA_W-1:0]      rx_data_q;
    logic                   rx_valid_q;
    logic                   underrun_q;

    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   lead;
    logic                   trail;
    logic                   sample;
    logic                   shift;
    logic                   shift_en;
    logic                   cs_fall;
    logic                   in_shift;
    logic                   last_bit;
    logic                   take;
    logic [DATA_W-1:0]      next_word;
    logic [DATA_W-1:0]      rx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sr  <= {SYNC_STAGES{IDLE_LVL}};
            cs_sr   <= '1;
            mosi_sr <= '0;
            sck_q   <= IDLE_LVL;
            cs_q    <= 1'b1;
        end else begin
            sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sck_q   <= sck_s;
            cs_q    <= cs_s;
        end
    end

    assign sck_s   = sck_sr[SYNC_STAGES-1];
    assign cs_s    = cs_sr[SYNC_STAGES-1];
    assign mosi_s  = mosi_sr[SYNC_STAGES-1];

    assign lead    = (sck_q == IDLE_LVL) && (sck_s != IDLE_LVL);
    assign trail   = (sck_q != IDLE_LVL) && (sck_s == IDLE_LVL);
    assign sample  = PHA ? trail : lead;
    assign shift   = PHA ? lead : trail;
    assign cs_fall = cs_q & ~cs_s;

    assign in_shift = (state == SHIFT);
    assign last_bit = in_shift && sample && (bit_cnt == '0);

    // CPHA=0: the trailing edge that closes the previous word arrives
    // before any sample of this word; it must not advance miso.
    assign shift_en = in_shift && shift && (PHA || (bit_cnt != LAST));

    assign take      = bus.tx_valid & ~buf_full;
    assign next_word = buf_full ? buf_data : DEFAULT_TX;
    assign rx_next   = {rx_shift, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cs_fall) state_nx = LOAD;
            end
            LOAD: begin
                state_nx = cs_s ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (last_bit)  state_nx = cs_s ? IDLE : LOAD;
                else if (cs_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full   <= 1'b0;
            buf_data   <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            bit_cnt    <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            // A load coinciding with LOAD refills the buffer for the next word.
            if (take) begin
                buf_full <= 1'b1;
                buf_data <= bus.tx_data;
            end else if (state == LOAD) begin
                buf_full <= 1'b0;
            end

            if (state == LOAD) begin
                bit_cnt    <= LAST;
                underrun_q <= ~buf_full;
                if (!PHA) begin
                    miso_q   <= next_word[DATA_W-1];
                    tx_shift <= {next_word[DATA_W-2:0], 1'b0};
                end else begin
                    tx_shift <= next_word;
                end
            end

            if (in_shift && sample) begin
                rx_shift <= rx_next[DATA_W-2:0];
                bit_cnt  <= bit_cnt - 1'b1;
                if (bit_cnt == '0) begin
                    rx_data_q  <= rx_next;
                    rx_valid_q <= 1'b1;
                end
            end

            if (shift_en) begin
                miso_q   <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign bus.busy        = ~cs_s;
    assign bus.tx_ready    = ~buf_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign miso_oe         = ~cs_s;
    assign miso            = miso_q & ~cs_s;

endmodule
